gb_array_decoder: RTL and testbench

//  Parametrised ghostbus fan-out stage. Decodes one host ghostbus onto NCH identical child

---
 rtl/gb_array_pkg.sv | 24 ++
 rtl/gb_rd_pipe.sv | 38 +++
 rtl/gb_array_decoder.sv | 137 +++++++++++++
 tb/tb_gb_array_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_array_pkg.sv
// gb_array_pkg: shared constants, read-target encoding and helpers for gb_array_decoder
package gb_array_pkg;

    // Status registers sit directly after the CSR bank: offset NCSR + *_OFS
    localparam int MISS_CNT_OFS  = 0;
    localparam int MISS_ADDR_OFS = 1;

    // Local page spans addresses 0 .. 2**LOCAL_PAGE_AW-1
    localparam int LOCAL_PAGE_AW = 4;

    typedef enum logic [1:0] {
        TGT_NONE  = 2'd0,
        TGT_LOCAL = 2'd1,
        TGT_CHILD = 2'd2
    } tgt_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/gb_rd_pipe.sv
// gb_rd_pipe: valid-tagged read-return shift pipeline of DEPTH stages
//   clk_i, rst_i : clock, asynchronous active-high reset
//   v_i, d_i     : stage-1 valid and data
//   v_o, d_o     : last-stage valid pulse and data (data holds between returns)
module gb_rd_pipe #(
    parameter int DW    = 32,
    parameter int DEPTH = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          v_i,
    input  logic [DW-1:0] d_i,
    output logic          v_o,
    output logic [DW-1:0] d_o
);

    logic [DEPTH-1:0] v_q;
    logic [DW-1:0]    d_q [DEPTH];

    // Data only moves with a valid tag, so the last stage holds the previous return
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
        end else begin
            v_q[0] <= v_i;
            if (v_i) d_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) d_q[k] <= d_q[k-1];
            end
        end
    end

    assign v_o = v_q[DEPTH-1];
    assign d_o = d_q[DEPTH-1];

endmodule

// File: rtl/gb_array_decoder.sv
// gb_array_decoder: ghostbus fan-out onto NCH child windows plus a local CSR bank
//   gb_clk, gb_rst          : clock, asynchronous active-high reset
//   gb_addr/wdata/wen/rstb  : host bus request (single-cycle strobes)
//   gb_rdata, gb_rvalid     : read return, RD_LAT cycles after gb_rstb
//   ch_addr, ch_wdata       : shared child-relative address and write data
//   ch_we, ch_rstb          : per-child strobes, at most one bit set
//   ch_rdata                : child read data, valid the cycle after ch_rstb
//   csr_out                 : local CSR values, CSR k at [(k+1)*CSR_W-1 -: CSR_W]
module gb_array_decoder
    import gb_array_pkg::*;
#(
    parameter int              AW      = 24,
    parameter int              DW      = 32,
    parameter int              NCH     = 4,
    parameter int              CH_AW   = 8,
    parameter logic [AW-1:0]   CH_BASE = 'h100,
    parameter int              NCSR    = 4,
    parameter int              CSR_W   = 8,
    parameter int              RD_LAT  = 2
) (
    input  logic                  gb_clk,
    input  logic                  gb_rst,
    input  logic [AW-1:0]         gb_addr,
    input  logic [DW-1:0]         gb_wdata,
    input  logic                  gb_wen,
    input  logic                  gb_rstb,
    output logic [DW-1:0]         gb_rdata,
    output logic                  gb_rvalid,
    output logic [CH_AW-1:0]      ch_addr,
    output logic [DW-1:0]         ch_wdata,
    output logic [NCH-1:0]        ch_we,
    output logic [NCH-1:0]        ch_rstb,
    input  logic [NCH*DW-1:0]     ch_rdata,
    output logic [NCSR*CSR_W-1:0] csr_out
);

    localparam int                     IW        = (NCH > 1) ? clog2(NCH) : 1;
    localparam logic [LOCAL_PAGE_AW-1:0] CNT_OFS   = LOCAL_PAGE_AW'(NCSR + MISS_CNT_OFS);
    localparam logic [LOCAL_PAGE_AW-1:0] MADDR_OFS = LOCAL_PAGE_AW'(NCSR + MISS_ADDR_OFS);

    logic [NCH-1:0]           hit;
    logic [LOCAL_PAGE_AW-1:0] ofs;
    logic                     loc_hit;
    logic                     miss;
    logic                     rd;
    logic [IW-1:0]            idx;
    logic [CSR_W-1:0]         csr_q [NCSR];
    logic [DW-1:0]            miss_cnt_q;
    logic [AW-1:0]            miss_addr_q;
    logic                     rd_v_q;
    tgt_e                     tgt_q;
    logic [IW-1:0]            idx_q;
    logic [LOCAL_PAGE_AW-1:0] ofs_q;
    logic [DW-1:0]            loc_val;
    logic [DW-1:0]            ch_val;
    logic [DW-1:0]            rd_d;

    assign ch_addr  = gb_addr[CH_AW-1:0];
    assign ch_wdata = gb_wdata;

    // Windows are aligned, so a hit is a compare of the bits above the window offset
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam logic [AW-1:0] BASE = CH_BASE + AW'(g * (2 ** CH_AW));
        assign hit[g]     = gb_addr[AW-1:CH_AW] == BASE[AW-1:CH_AW];
        assign ch_we[g]   = gb_wen & hit[g];
        assign ch_rstb[g] = gb_rstb & hit[g] & ~gb_wen;
    end

    assign ofs     = gb_addr[LOCAL_PAGE_AW-1:0];
    assign loc_hit = (gb_addr[AW-1:LOCAL_PAGE_AW] == '0) && (ofs <= MADDR_OFS);
    assign miss    = (gb_wen | gb_rstb) & ~(loc_hit | (|hit));
    // A write in the same cycle wins; the read is dropped
    assign rd      = gb_rstb & ~gb_wen;

    always_comb begin
        idx = '0;
        for (int n = 0; n < NCH; n++) if (hit[n]) idx = IW'(n);
    end

    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            for (int k = 0; k < NCSR; k++) csr_q[k] <= '0;
            miss_cnt_q  <= '0;
            miss_addr_q <= '0;
        end else begin
            for (int k = 0; k < NCSR; k++)
                if (gb_wen && loc_hit && ofs == LOCAL_PAGE_AW'(k)) csr_q[k] <= gb_wdata[CSR_W-1:0];
            if (gb_wen && loc_hit && ofs == CNT_OFS) miss_cnt_q <= '0;
            else if (miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            if (miss) miss_addr_q <= gb_addr;
        end
    end

    always_comb begin
        csr_out = '0;
        for (int k = 0; k < NCSR; k++) csr_out[k*CSR_W +: CSR_W] = csr_q[k];
    end

    // Request stage: remember what was read so the return mux runs one cycle later,
    // when the child data is valid
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            rd_v_q <= 1'b0;
            tgt_q  <= TGT_NONE;
            idx_q  <= '0;
            ofs_q  <= '0;
        end else begin
            rd_v_q <= rd;
            if (rd) begin
                tgt_q <= loc_hit ? TGT_LOCAL : (|hit) ? TGT_CHILD : TGT_NONE;
                idx_q <= idx;
                ofs_q <= ofs;
            end
        end
    end

    always_comb begin
        loc_val = (ofs_q == CNT_OFS) ? miss_cnt_q : (ofs_q == MADDR_OFS) ? DW'(miss_addr_q) : '0;
        for (int k = 0; k < NCSR; k++) if (ofs_q == LOCAL_PAGE_AW'(k)) loc_val = DW'(csr_q[k]);
        ch_val = '0;
        for (int n = 0; n < NCH; n++) if (idx_q == IW'(n)) ch_val = ch_rdata[n*DW +: DW];
        rd_d = (tgt_q == TGT_LOCAL) ? loc_val : (tgt_q == TGT_CHILD) ? ch_val : '0;
    end

    gb_rd_pipe #(
        .DW    (DW),
        .DEPTH (RD_LAT - 1)
    ) u_rd_pipe (
        .clk_i (gb_clk),
        .rst_i (gb_rst),
        .v_i   (rd_v_q),
        .d_i   (rd_d),
        .v_o   (gb_rvalid),
        .d_o   (gb_rdata)
    );

endmodule

// File: tb/tb_gb_array_decoder.sv
// tb_gb_array_decoder: self-checking bench with a behavioural address-map model
module tb_gb_array_decoder;
  localparam int AW = 24, DW = 32, NCH = 4, CH_AW = 8, NCSR = 4, CSR_W = 8;
  localparam int CH_BASE = 'h100;
  localparam int WIN = 2 ** CH_AW;
  logic gb_clk = 1'b0;
  logic gb_rst = 1'b0;
  logic [AW-1:0] gb_addr = '0;
  logic [DW-1:0] gb_wdata = '0;
  logic gb_wen = 1'b0;
  logic gb_rstb = 1'b0;
  logic [DW-1:0] rdata2, rdata4, ch_wdata, ch_wdata4;
  logic rvalid2, rvalid4;
  logic [CH_AW-1:0] ch_addr, ch_addr4;
  logic [NCH-1:0] ch_we, ch_rstb, ch_we4, ch_rstb4;
  logic [NCH*DW-1:0] ch_rdata = '0;
  logic [NCSR*CSR_W-1:0] csr_out, csr_out4;
  int n_chk = 0;
  int n_fail = 0;
  logic [CSR_W-1:0] m_csr [NCSR];
  logic [DW-1:0] m_cnt;
  logic [AW-1:0] m_maddr;
  always #5 gb_clk = ~gb_clk;
  gb_array_decoder dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
    .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(rdata2), .gb_rvalid(rvalid2),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_we(ch_we), .ch_rstb(ch_rstb),
    .ch_rdata(ch_rdata), .csr_out(csr_out)
  );
  gb_array_decoder #(.RD_LAT(4)) dut4 (
    .gb_clk(gb_clk), .gb_rst(gb_rst), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
    .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(rdata4), .gb_rvalid(rvalid4),
    .ch_addr(ch_addr4), .ch_wdata(ch_wdata4), .ch_we(ch_we4), .ch_rstb(ch_rstb4),
    .ch_rdata(ch_rdata), .csr_out(csr_out4)
  );
  always @(posedge gb_clk)
    for (int n = 0; n < NCH; n++)
      if (ch_rstb[n]) ch_rdata[n*DW +: DW] <= {16'hA5A5, ch_addr, 8'(n)};
  task automatic check(input bit ok, input string msg);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s", msg);
    end
  endtask
  function automatic int child_of(input int a);
    if (a >= CH_BASE && a < CH_BASE + NCH * WIN) return (a - CH_BASE) / WIN;
    return -1;
  endfunction
  function automatic logic [DW-1:0] model(input int a, input logic [DW-1:0] wd, input bit we, input bit rs);
    logic [DW-1:0] rv;
    bit unm;
    int c;
    rv = '0;
    unm = 0;
    c = child_of(a);
    if (a < 16) begin
      if (a < NCSR) rv = DW'(m_csr[a]);
      else if (a == NCSR) rv = m_cnt;
      else if (a == NCSR + 1) rv = DW'(m_maddr);
      else unm = 1;
    end else if (c >= 0) rv = {16'hA5A5, 8'(a % WIN), 8'(c)};
    else unm = 1;
    if (we && a < NCSR) m_csr[a] = wd[CSR_W-1:0];
    if (we && a == NCSR) m_cnt = '0;
    if ((we || rs) && unm) begin
      if (m_cnt != '1) m_cnt = m_cnt + 1;
      m_maddr = AW'(a);
    end
    return rv;
  endfunction
  function automatic logic [NCSR*CSR_W-1:0] exp_csr();
    logic [NCSR*CSR_W-1:0] r;
    for (int k = 0; k < NCSR; k++) r[k*CSR_W +: CSR_W] = m_csr[k];
    return r;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < NCSR; k++) m_csr[k] = '0;
    m_cnt = '0;
    m_maddr = '0;
  endtask
  task automatic step();
    @(posedge gb_clk);
    #1;
  endtask
  task automatic idle();
    gb_wen = 1'b0;
    gb_rstb = 1'b0;
  endtask
  task automatic access(input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit we, input bit rs,
                        output logic [DW-1:0] ex);
    gb_addr = a;
    gb_wdata = wd;
    gb_wen = we;
    gb_rstb = rs;
    ex = model(int'(a), wd, we, rs);
  endtask
  task automatic test_reset();
    logic [DW-1:0] ex;
    model_reset();
    #1 gb_rst = 1'b1;
    repeat (2) step();
    gb_rst = 1'b0;
    step();
    check(rvalid2 === 1'b0 && rdata2 === '0, $sformatf("reset_out: got rvalid=%b rdata=%h expected 0/0", rvalid2, rdata2));
    check(csr_out === '0, $sformatf("reset_csr: got %h expected 0", csr_out));
    access('h0, 'h11, 1, 0, ex);
    step();
    idle();
    check(csr_out === exp_csr(), $sformatf("reset_csr_load: got %h expected %h", csr_out, exp_csr()));
    access('h300, '0, 0, 1, ex);
    step();
    idle();
    gb_rst = 1'b1;
    model_reset();
    step();
    check(rvalid2 === 1'b0 && rdata2 === '0, $sformatf("reset_midread: got rvalid=%b rdata=%h expected 0/0", rvalid2, rdata2));
    check(csr_out === '0, $sformatf("reset_midread_csr: got %h expected 0", csr_out));
    gb_rst = 1'b0;
    repeat (3) begin
      step();
      check(rvalid2 === 1'b0 && rvalid4 === 1'b0, $sformatf("reset_discard: got rvalid2=%b rvalid4=%b expected 0/0", rvalid2, rvalid4));
    end
  endtask
  task automatic test_child();
    logic [DW-1:0] ex;
    access('h300, '0, 0, 1, ex);
    #1;
    check(ch_rstb === 4'b0100 && ch_we === '0 && ch_addr === '0, $sformatf("child_strobe: got rstb=%b we=%b addr=%h expected 0100/0000/00", ch_rstb, ch_we, ch_addr));
    step();
    idle();
    check(rvalid2 === 1'b0, $sformatf("child_early: got rvalid=%b expected 0", rvalid2));
    step();
    check(rvalid2 === 1'b1 && rdata2 === ex, $sformatf("child_return: got rvalid=%b rdata=%h expected 1/%h", rvalid2, rdata2, ex));
    step();
    check(rvalid2 === 1'b0 && rdata2 === ex, $sformatf("child_hold: got rvalid=%b rdata=%h expected 0/%h", rvalid2, rdata2, ex));
    step();
    check(rvalid4 === 1'b1 && rdata4 === ex, $sformatf("child_lat4: got rvalid=%b rdata=%h expected 1/%h", rvalid4, rdata4, ex));
    repeat (2) step();
  endtask
  task automatic test_csr();
    logic [DW-1:0] ex;
    access('h1, 'h1234_5677, 1, 0, ex);
    step();
    idle();
    check(csr_out === exp_csr(), $sformatf("csr_write: got %h expected %h", csr_out, exp_csr()));
    access('h1, '0, 0, 1, ex);
    step();
    idle();
    step();
    check(rvalid2 === 1'b1 && rdata2 === ex, $sformatf("csr_read: got rvalid=%b rdata=%h expected 1/%h", rvalid2, rdata2, ex));
    repeat (3) step();
  endtask
  task automatic test_miss();
    int ta [11] = '{'h50_0000, 'h5, 'h7, 'h4, 'h5, 'h4, 'h4, 'h5, 'h4, 'h5, 'h6};
    bit tw [11] = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    logic [DW-1:0] ex;
    for (int i = 0; i < 11; i++) begin
      access(AW'(ta[i]), 32'h0000_FFFF, tw[i], !tw[i], ex);
      step();
      idle();
      step();
      if (!tw[i]) check(rvalid2 === 1'b1 && rdata2 === ex, $sformatf("miss_read_%0d: got rvalid=%b rdata=%h expected 1/%h", i, rvalid2, rdata2, ex));
      else check(rvalid2 === 1'b0, $sformatf("miss_write_%0d: got rvalid=%b expected 0", i, rvalid2));
    end
    repeat (3) step();
  endtask
  task automatic test_collision();
    logic [DW-1:0] ex;
    access('h200, 'hDEAD_BEEF, 1, 1, ex);
    #1;
    check(ch_we === 4'b0010 && ch_rstb === '0 && ch_wdata === 'hDEAD_BEEF, $sformatf("coll_strobe: got we=%b rstb=%b wdata=%h expected 0010/0000/deadbeef", ch_we, ch_rstb, ch_wdata));
    step();
    access('h60_0000, '0, 1, 1, ex);
    step();
    idle();
    repeat (3) begin
      check(rvalid2 === 1'b0 && rvalid4 === 1'b0, $sformatf("coll_norvalid: got rvalid2=%b rvalid4=%b expected 0/0", rvalid2, rvalid4));
      step();
    end
    access('h4, '0, 0, 1, ex);
    step();
    idle();
    step();
    check(rvalid2 === 1'b1 && rdata2 === ex, $sformatf("coll_misscnt: got rvalid=%b rdata=%h expected 1/%h", rvalid2, rdata2, ex));
    repeat (3) step();
  endtask
  task automatic test_back_to_back();
    int ta [10] = '{'h112, 'h2FF, 'h300, 'h4FF, 'h1, 'h4, 'h7, 'h4, 'h500, 'h5};
    bit hv [$];
    logic [DW-1:0] hd [$];
    logic [DW-1:0] ex, h2, h4;
    bit g2, g4;
    g2 = 0;
    g4 = 0;
    for (int i = 0; i < 13; i++) begin
      if (i < 10) access(AW'(ta[i]), '0, 0, 1, ex);
      else begin
        idle();
        ex = '0;
      end
      hv.push_back(i < 10);
      hd.push_back(ex);
      step();
      check(rvalid2 === (i >= 1 && hv[i-1]), $sformatf("b2b_rvalid2_%0d: got %b", i, rvalid2));
      if (i >= 1 && hv[i-1]) begin h2 = hd[i-1]; g2 = 1; end
      if (g2) check(rdata2 === h2, $sformatf("b2b_rdata2_%0d: got %h expected %h", i, rdata2, h2));
      check(rvalid4 === (i >= 3 && hv[i-3]), $sformatf("b2b_rvalid4_%0d: got %b", i, rvalid4));
      if (i >= 3 && hv[i-3]) begin h4 = hd[i-3]; g4 = 1; end
      if (g4) check(rdata4 === h4, $sformatf("b2b_rdata4_%0d: got %h expected %h", i, rdata4, h4));
    end
    repeat (3) step();
  endtask
  task automatic test_random();
    bit hv [$];
    logic [DW-1:0] hd [$];
    logic [DW-1:0] ex, h2, h4;
    bit g2, g4;
    g2 = 0;
    g4 = 0;
    for (int i = 0; i < 303; i++) begin
      int sel, c;
      bit we, rs;
      logic [AW-1:0] a;
      logic [NCH-1:0] ew, er;
      int edge_a [5] = '{'hFF, 'h500, 'h10, 'h4FF, 'h100};
      we = 0;
      rs = 0;
      a = '0;
      if (i < 300) begin
        sel = $urandom_range(0, 4);
        a = (sel == 0) ? AW'($urandom_range(0, 15)) :
            (sel <= 2) ? AW'(CH_BASE + $urandom_range(0, NCH * WIN - 1)) :
            (sel == 3) ? AW'(edge_a[$urandom_range(0, 4)]) : AW'($urandom);
        we = $urandom_range(0, 3) == 0;
        rs = $urandom_range(0, 1) == 1;
      end
      access(a, $urandom, we, rs, ex);
      #1;
      c = child_of(int'(a));
      ew = (we && c >= 0) ? NCH'(1) << c : '0;
      er = (rs && !we && c >= 0) ? NCH'(1) << c : '0;
      check(ch_we === ew && ch_rstb === er, $sformatf("rnd_strobe_%0d: got we=%b rstb=%b expected %b/%b", i, ch_we, ch_rstb, ew, er));
      hv.push_back(rs && !we);
      hd.push_back(ex);
      step();
      check(rvalid2 === (i >= 1 && hv[i-1]), $sformatf("rnd_rvalid2_%0d: got %b", i, rvalid2));
      if (i >= 1 && hv[i-1]) begin h2 = hd[i-1]; g2 = 1; end
      if (g2) check(rdata2 === h2, $sformatf("rnd_rdata2_%0d: got %h expected %h", i, rdata2, h2));
      check(rvalid4 === (i >= 3 && hv[i-3]), $sformatf("rnd_rvalid4_%0d: got %b", i, rvalid4));
      if (i >= 3 && hv[i-3]) begin h4 = hd[i-3]; g4 = 1; end
      if (g4) check(rdata4 === h4, $sformatf("rnd_rdata4_%0d: got %h expected %h", i, rdata4, h4));
      check(csr_out === exp_csr(), $sformatf("rnd_csr_%0d: got %h expected %h", i, csr_out, exp_csr()));
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_child();
    test_csr();
    test_miss();
    test_collision();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
